uart_rx_deser: RTL and testbench

Parametrised successor to the UART RX serial shift register. Tracks its own frame position, assembles DATA_BITS LSB-first and checks optional parity and the stop bit. Presents a registered word with done/error flags to the TramelBlaze-side RX interface. Sits between the RX bit-timing engine, which supplies start/shift strobes, and the RX status/data port.

---
 rtl/uart_rx_pkg.sv | 20 ++
 rtl/uart_rx_bitcnt.sv | 41 ++++
 rtl/uart_rx_deser.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_deser.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART RX deserialiser.
package uart_rx_pkg;

  // Frame position of the receiver.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  // Parity mode encodings for parity_odd.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Supported DATA_BITS range.
  localparam int unsigned DATA_BITS_MIN = 5;
  localparam int unsigned DATA_BITS_MAX = 9;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_bitcnt.sv
// Frame-position counter: clears on start, counts data-bit shifts and flags
// the shift that completes the data field.
module uart_rx_bitcnt #(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned TERM  = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             tc_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  // High while the next data shift is the last one of the data field.
  assign tc_c = (cnt_q == CNT_W'(TERM - 1));

endmodule : uart_rx_bitcnt

// File: rtl/uart_rx_deser.sv
// UART RX deserialiser: assembles DATA_BITS LSB-first from timing-engine
// strobes, checks optional parity and the stop bit, and presents a registered
// word with done/error flags.
// Optional feature macro: UART_RX_OVERRUN_EN (unread/overrun tracking with ack).
module uart_rx_deser
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned BIT_CNT_W = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 shift,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 ack,
  output logic [DATA_BITS-1:0] data,
  output logic                 done,
  output logic                 busy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  rx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic                 par_bit_q, par_bit_d;
  logic                 par_en_l_q, par_en_l_d;
  logic                 par_odd_l_q, par_odd_l_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;

  logic                 cnt_clr_c;
  logic                 cnt_inc_c;
  logic                 cnt_tc_c;
  logic                 complete_c;
  logic                 exp_par_c;
  logic [BIT_CNT_W-1:0] unused_bit_cnt;

  uart_rx_bitcnt #(
    .CNT_W (BIT_CNT_W),
    .TERM  (DATA_BITS)
  ) u_bitcnt (
    .clock (clock),
    .reset (reset),
    .clear (cnt_clr_c),
    .inc   (cnt_inc_c),
    .cnt   (unused_bit_cnt),
    .tc_c  (cnt_tc_c)
  );

  // Parity bit the sender should have produced for the assembled word.
  assign exp_par_c = (^sr_q) ^ (par_odd_l_q == PAR_ODD);

  // Next-state, shift register and completion-flag logic; start beats shift.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    par_bit_d    = par_bit_q;
    par_en_l_d   = par_en_l_q;
    par_odd_l_d  = par_odd_l_q;
    data_d       = data_q;
    done_d       = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    cnt_clr_c    = 1'b0;
    cnt_inc_c    = 1'b0;
    complete_c   = 1'b0;

    if (start) begin
      state_d     = DATA;
      cnt_clr_c   = 1'b1;
      par_en_l_d  = parity_en;
      par_odd_l_d = parity_odd;
    end else if (shift) begin
      unique case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        DATA: begin
          sr_d      = {rx, sr_q[DATA_BITS-1:1]};
          cnt_inc_c = 1'b1;
          if (cnt_tc_c) begin
            state_d = par_en_l_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_bit_d = rx;
          state_d   = STOP;
        end
        STOP: begin
          complete_c   = 1'b1;
          state_d      = IDLE;
          data_d       = sr_q;
          frame_err_d  = ~rx;
          parity_err_d = par_en_l_q & (par_bit_q != exp_par_c);
          done_d       = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // Frame state, shift register and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      par_bit_q    <= 1'b0;
      par_en_l_q   <= 1'b0;
      par_odd_l_q  <= PAR_EVEN;
      data_q       <= '0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      par_bit_q    <= par_bit_d;
      par_en_l_q   <= par_en_l_d;
      par_odd_l_q  <= par_odd_l_d;
      data_q       <= data_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

`ifdef UART_RX_OVERRUN_EN
  logic unread_q, unread_d;
  logic overrun_q, overrun_d;

  // Unread/overrun tracking; a completion coincident with ack never overruns.
  always_comb begin
    unread_d  = unread_q;
    overrun_d = overrun_q;
    if (complete_c) begin
      unread_d = 1'b1;
    end else if (ack) begin
      unread_d = 1'b0;
    end
    if (ack) begin
      overrun_d = 1'b0;
    end else if (complete_c && unread_q) begin
      overrun_d = 1'b1;
    end
  end

  // Overrun state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      unread_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      unread_q  <= unread_d;
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  logic unused_ack;
  logic unused_complete;

  assign unused_ack      = ack;
  assign unused_complete = complete_c;
  assign overrun         = 1'b0;
`endif

  assign data       = data_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule : uart_rx_deser

// File: tb/tb_uart_rx_deser.sv
// Directed self-checking bench for uart_rx_deser (DATA_BITS = 8).
module tb_uart_rx_deser;

  localparam int unsigned DB = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          shift = 1'b0;
  logic          rx = 1'b1;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic          ack = 1'b0;
  logic [DB-1:0] data;
  logic          done;
  logic          busy;
  logic          parity_err;
  logic          frame_err;
  logic          overrun;

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;
  int base;

  uart_rx_deser #(.DATA_BITS(DB), .BIT_CNT_W(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .shift      (shift),
    .rx         (rx),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .ack        (ack),
    .data       (data),
    .done       (done),
    .busy       (busy),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  // Counts every cycle in which done was high.
  always @(posedge clock) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle of strobes driven at negedge, returning at the negedge after the edge.
  task automatic strobe(input logic st, input logic sh, input logic r, input logic a);
    @(negedge clock);
    start = st;
    shift = sh;
    rx    = r;
    ack   = a;
    @(negedge clock);
    start = 1'b0;
    shift = 1'b0;
    ack   = 1'b0;
    rx    = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Full frame: start, DB data bits LSB first, optional parity bit, stop bit.
  task automatic send_frame(input logic [DB-1:0] d, input logic pe, input logic po,
                            input logic pb, input logic sb, input logic ack_at_stop);
    parity_en  = pe;
    parity_odd = po;
    strobe(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < int'(DB); i++) strobe(1'b0, 1'b1, d[i], 1'b0);
    if (pe) strobe(1'b0, 1'b1, pb, 1'b0);
    strobe(1'b0, 1'b1, sb, ack_at_stop);
  endtask

  initial begin
    // Reset state
    idle(3);
    reset = 1'b0;
    idle(1);
    check("rst_data", 32'(data), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_perr", 32'(parity_err), 32'h0);
    check("rst_ferr", 32'(frame_err), 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);

    // 8N1 0xA5
    base = done_cnt;
    parity_en = 1'b0;
    strobe(1'b1, 1'b0, 1'b1, 1'b0);
    check("busy_after_start", 32'(busy), 32'h1);
    for (int i = 0; i < 8; i++) strobe(1'b0, 1'b1, ((8'hA5 >> i) & 8'h1) != 0, 1'b0);
    check("busy_before_stop", 32'(busy), 32'h1);
    strobe(1'b0, 1'b1, 1'b1, 1'b0);
    check("a5_done", 32'(done), 32'h1);
    check("a5_busy", 32'(busy), 32'h0);
    check("a5_data", 32'(data), 32'hA5);
    check("a5_perr", 32'(parity_err), 32'h0);
    check("a5_ferr", 32'(frame_err), 32'h0);
    idle(1);
    check("a5_done_drop", 32'(done), 32'h0);
    idle(2);
    check("a5_done_once", 32'(done_cnt - base), 32'h1);

    // 8E1 0x07: correct parity 1, then wrong parity 0
    send_frame(8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("e07_perr_ok", 32'(parity_err), 32'h0);
    check("e07_data", 32'(data), 32'h07);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("e07_perr_bad", 32'(parity_err), 32'h1);
    check("e07_data2", 32'(data), 32'h07);

    // 8O1 0x00, parity 1, stop bit 0
    send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("o00_perr", 32'(parity_err), 32'h0);
    check("o00_ferr", 32'(frame_err), 32'h1);
    check("o00_data", 32'(data), 32'h00);
    check("o00_done", 32'(done), 32'h1);

    // Abort after 3 shifts, then full frame 0x0A
    idle(2);
    base = done_cnt;
    parity_en = 1'b0;
    strobe(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) strobe(1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'h0A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("abort_data", 32'(data), 32'h0A);
    check("abort_ferr", 32'(frame_err), 32'h0);
    idle(2);
    check("abort_one_done", 32'(done_cnt - base), 32'h1);

    // Hold outputs; shifts while idle are ignored
    base = done_cnt;
    for (int i = 0; i < 12; i++) strobe(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("idle_shift_nodone", 32'(done_cnt - base), 32'h0);
    check("idle_shift_data", 32'(data), 32'h0A);
    check("idle_shift_busy", 32'(busy), 32'h0);

    // parity_en raised mid-frame has no effect: 9th shift is the stop bit
    parity_en = 1'b0;
    strobe(1'b1, 1'b0, 1'b1, 1'b0);
    parity_en = 1'b1;
    for (int i = 0; i < 8; i++) strobe(1'b0, 1'b1, ((8'h3C >> i) & 8'h1) != 0, 1'b0);
    strobe(1'b0, 1'b1, 1'b1, 1'b0);
    check("midpe_done", 32'(done), 32'h1);
    check("midpe_data", 32'(data), 32'h3C);
    check("midpe_perr", 32'(parity_err), 32'h0);

    // start and shift together: shift ignored
    parity_en = 1'b0;
    strobe(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) strobe(1'b0, 1'b1, ((8'h81 >> i) & 8'h1) != 0, 1'b0);
    strobe(1'b0, 1'b1, 1'b1, 1'b0);
    check("stsh_done", 32'(done), 32'h1);
    check("stsh_data", 32'(data), 32'h81);

    // Reset after 4 data shifts of 0xFF
    idle(2);
    strobe(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) strobe(1'b0, 1'b1, 1'b1, 1'b0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("midrst_data", 32'(data), 32'h0);
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    check("midrst_ferr", 32'(frame_err), 32'h0);
    base = done_cnt;
    for (int i = 0; i < 6; i++) strobe(1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);
    check("midrst_nodone", 32'(done_cnt - base), 32'h0);
    check("midrst_data2", 32'(data), 32'h0);

    // Two frames without ack
    send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_data", 32'(data), 32'h22);
`ifdef UART_RX_OVERRUN_EN
    check("ovr_set", 32'(overrun), 32'h1);
    strobe(1'b0, 1'b0, 1'b1, 1'b1);
    check("ovr_ack_clr", 32'(overrun), 32'h0);
    send_frame(8'h33, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h44, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("ovr_coinc_data", 32'(data), 32'h44);
    check("ovr_coinc", 32'(overrun), 32'h0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("ovr_after_coinc", 32'(overrun), 32'h1);
`else
    check("ovr_off", 32'(overrun), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_uart_rx_deser
